// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Fetch-stage program-counter generator with configurable width,
//             step and reset vector. Accepts redirect, return, call and jump
//             requests in fixed priority; all state changes on the falling
//             edge of clk so the PC is stable at the next rising edge.
//  Option   : PC_GEN_RAS_EN - builds the return-address stack. Without it,
//             call acts as jump, ret is ignored and the RAS flags are tied off.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int PC_W      = 7,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            jump,
  input  logic            call,
  input  logic [PC_W-1:0] jump_pc,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc,
  output logic            wrap,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam logic [PC_W-1:0] STEP_V      = PC_W'(STEP);
  localparam logic [PC_W-1:0] RESET_V     = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] RESET_INC_V = PC_W'(RESET_PC + STEP);

  logic [PC_W-1:0] pc_next;
  logic            seq_next;
  logic            carry;

  // pc + STEP overflows exactly when pc exceeds (2^PC_W - 1 - STEP) = ~STEP
  assign carry = (pc > ~STEP_V);

`ifdef PC_GEN_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_err_q;
  logic             push;
  logic             pop;
  logic             ras_fault;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_FULL);
  assign ras_err   = ras_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ret | (RAS_DEPTH < 2);
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

  // Next-PC selection in strict priority: redirect, ret, call, jump, sequential
  always_comb begin
    pc_next  = pc_inc;
    seq_next = 1'b1;
`ifdef PC_GEN_RAS_EN
    push      = 1'b0;
    pop       = 1'b0;
    ras_fault = 1'b0;
`endif
    if (redirect) begin
      pc_next  = redirect_pc;
      seq_next = 1'b0;
    end
`ifdef PC_GEN_RAS_EN
    else if (ret) begin
      // An empty stack falls back to the sequential address and flags an error
      if (!ras_empty) begin
        pc_next  = ras_mem[ras_top];
        seq_next = 1'b0;
        pop      = 1'b1;
      end else begin
        ras_fault = 1'b1;
      end
    end
    else if (call) begin
      pc_next   = jump_pc;
      seq_next  = 1'b0;
      push      = 1'b1;
      ras_fault = ras_full;
    end
`endif
    else if (jump || call) begin
      pc_next  = jump_pc;
      seq_next = 1'b0;
    end
  end

  // PC, its successor and the wrap pulse, all registered on the falling edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_V;
      pc_inc <= RESET_INC_V;
      wrap   <= 1'b0;
    end else if (enable) begin
      pc     <= pc_next;
      pc_inc <= pc_next + STEP_V;
      wrap   <= seq_next & carry;
    end else begin
      wrap   <= 1'b0;
    end
  end

`ifdef PC_GEN_RAS_EN
  // Stack pointer, saturating occupancy count and sticky error flag
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ras_top   <= '0;
      ras_cnt   <= '0;
      ras_err_q <= 1'b0;
    end else if (enable) begin
      if (push) begin
        // When full the pointer advances onto the oldest entry, replacing it
        ras_top <= ras_top + PTR_ONE;
        if (!ras_full) ras_cnt <= ras_cnt + CNT_ONE;
      end else if (pop) begin
        ras_top <= ras_top - PTR_ONE;
        ras_cnt <= ras_cnt - CNT_ONE;
      end
      if (ras_fault) ras_err_q <= 1'b1;
    end
  end

  // Stack storage; a push writes the slot just above the current top
  always_ff @(negedge clk) begin
    if (enable && push) ras_mem[ras_top + PTR_ONE] <= pc_inc;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen (PC_W=7, STEP=1, RESET_PC=0,
//             RAS_DEPTH=4). A behavioural model pushes expected outputs into
//             a scoreboard queue as each edge is driven; each scenario pops
//             and compares after the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  typedef struct packed {
    logic [6:0] pc;
    logic [6:0] inc;
    logic       wrap;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       redirect;
  logic [6:0] redirect_pc;
  logic       jump;
  logic       call;
  logic [6:0] jump_pc;
  logic       ret;
  logic [6:0] pc;
  logic [6:0] pc_inc;
  logic       wrap;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  int compared   = 0;
  int mismatched = 0;

  exp_t       sb[$];
  logic [6:0] m_pc;
  logic [6:0] m_inc;
  logic       m_wrap;
  logic       m_err;
  logic [6:0] m_stack[$];

  pc_gen #(.PC_W(7), .STEP(1), .RESET_PC(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .jump(jump), .call(call), .jump_pc(jump_pc), .ret(ret),
    .pc(pc), .pc_inc(pc_inc), .wrap(wrap),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc   = 7'd0;
    m_inc  = 7'd1;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    m_stack.delete();
  endtask

  task automatic clear_req();
    redirect = 0; jump = 0; call = 0; ret = 0;
    redirect_pc = '0; jump_pc = '0;
  endtask

  // Model the edge from the current inputs, queue the expectation, run the edge
  task automatic advance();
    exp_t       e;
    logic [6:0] nxt;
    logic       seq;
    if (!enable) begin
      m_wrap = 1'b0;
    end else begin
      nxt = m_inc;
      seq = 1'b1;
      if (redirect) begin
        nxt = redirect_pc; seq = 1'b0;
      end
`ifdef PC_GEN_RAS_EN
      else if (ret) begin
        if (m_stack.size() > 0) begin
          nxt = m_stack.pop_back(); seq = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      else if (call) begin
        nxt = jump_pc; seq = 1'b0;
        m_stack.push_back(m_inc);
        if (m_stack.size() > 4) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
      end
`endif
      else if (jump || call) begin
        nxt = jump_pc; seq = 1'b0;
      end
      m_wrap = seq && (m_pc == 7'd127);
      m_pc   = nxt;
      m_inc  = nxt + 7'd1;
    end
    e.pc   = m_pc;
    e.inc  = m_inc;
    e.wrap = m_wrap;
`ifdef PC_GEN_RAS_EN
    e.empty = (m_stack.size() == 0);
    e.full  = (m_stack.size() == 4);
    e.err   = m_err;
`else
    e.empty = 1'b1;
    e.full  = 1'b0;
    e.err   = 1'b0;
`endif
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 0; enable = 0; clear_req(); model_reset();
    #12;
    got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
    compared++;
    if (got !== {7'd0, 7'd1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset: got pc=%0d inc=%0d w/e/f/err=%b%b%b%b, want 0 1 0100",
               got.pc, got.inc, got.wrap, got.empty, got.full, got.err);
    end
    rst = 1;
  endtask

  task automatic test_seq_wrap();
    exp_t got, e;
    int wraps = 0;
    enable = 1;
    for (int i = 0; i < 128; i++) begin
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL seq_wrap[%0d]: got pc=%0d inc=%0d wrap=%b, want pc=%0d inc=%0d wrap=%b",
                 i, got.pc, got.inc, got.wrap, e.pc, e.inc, e.wrap);
      end
      if (wrap === 1'b1) wraps++;
    end
    compared++;
    if (wraps !== 1 || pc !== 7'd0) begin
      mismatched++;
      $display("FAIL seq_wrap_count: got wraps=%0d pc=%0d, want wraps=1 pc=0", wraps, pc);
    end
  endtask

  task automatic test_stall();
    exp_t got, e;
    for (int i = 0; i < 10; i++) advance();
    for (int i = 0; i < 10; i++) void'(sb.pop_front());
    enable = 0; jump = 1; jump_pc = 7'd50;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) enable = 1;
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e || (i < 5 && pc !== 7'd10) || (i == 5 && pc !== 7'd50)) begin
        mismatched++;
        $display("FAIL stall[%0d]: got pc=%0d inc=%0d wrap=%b, want pc=%0d inc=%0d wrap=%b",
                 i, got.pc, got.inc, got.wrap, e.pc, e.inc, e.wrap);
      end
    end
    clear_req();
  endtask

  task automatic test_call_return();
    exp_t got, e;
    // op: 0 redirect to 5, 1 call 40, 2 seq, 3 seq, 4 ret
    for (int i = 0; i < 5; i++) begin
      clear_req();
      case (i)
        0: begin redirect = 1; redirect_pc = 7'd5; end
        1: begin call = 1; jump_pc = 7'd40; end
        4: ret = 1;
        default: ;
      endcase
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL call_return[%0d]: got pc=%0d inc=%0d e/f/err=%b%b%b, want pc=%0d inc=%0d e/f/err=%b%b%b",
                 i, got.pc, got.inc, got.empty, got.full, got.err, e.pc, e.inc, e.empty, e.full, e.err);
      end
    end
`ifdef PC_GEN_RAS_EN
    compared++;
    if (pc !== 7'd6 || ras_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL call_return_end: got pc=%0d empty=%b, want pc=6 empty=1", pc, ras_empty);
    end
`endif
    clear_req();
  endtask

  task automatic test_ras_overflow();
    exp_t got, e;
    logic [6:0] tgt;
    for (int i = 0; i < 11; i++) begin
      clear_req();
      if (i == 0) begin
        redirect = 1; redirect_pc = 7'd1;
      end else if (i <= 5) begin
        tgt = 7'(i * 10 + 1);
        call = 1; jump_pc = tgt;
      end else begin
        ret = 1;
      end
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL ras_overflow[%0d]: got pc=%0d inc=%0d e/f/err=%b%b%b, want pc=%0d inc=%0d e/f/err=%b%b%b",
                 i, got.pc, got.inc, got.empty, got.full, got.err, e.pc, e.inc, e.empty, e.full, e.err);
      end
    end
`ifdef PC_GEN_RAS_EN
    compared++;
    if (pc !== 7'd13 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL ras_underflow_end: got pc=%0d err=%b empty=%b, want pc=13 err=1 empty=1",
               pc, ras_err, ras_empty);
    end
`endif
    clear_req();
  endtask

  task automatic test_priority();
    exp_t got, e;
    // op: 0 call 80 (one entry), 1 redirect+ret+call, 2 ret (entry must survive)
    for (int i = 0; i < 3; i++) begin
      clear_req();
      case (i)
        0: begin call = 1; jump_pc = 7'd80; end
        1: begin redirect = 1; redirect_pc = 7'd99; ret = 1; call = 1; jump = 1; jump_pc = 7'd20; end
        default: ret = 1;
      endcase
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e || (i == 1 && pc !== 7'd99)) begin
        mismatched++;
        $display("FAIL priority[%0d]: got pc=%0d inc=%0d e/f/err=%b%b%b, want pc=%0d inc=%0d e/f/err=%b%b%b",
                 i, got.pc, got.inc, got.empty, got.full, got.err, e.pc, e.inc, e.empty, e.full, e.err);
      end
    end
    clear_req();
  endtask

  task automatic test_async_reset();
    exp_t got, e;
    // Build pc=70 with two stacked entries, then reset between edges
    for (int i = 0; i < 3; i++) begin
      clear_req();
      case (i)
        0: begin redirect = 1; redirect_pc = 7'd60; end
        1: begin call = 1; jump_pc = 7'd65; end
        default: begin call = 1; jump_pc = 7'd70; end
      endcase
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL async_setup[%0d]: got pc=%0d inc=%0d, want pc=%0d inc=%0d",
                 i, got.pc, got.inc, e.pc, e.inc);
      end
    end
    clear_req();
    rst = 0;
    #2;
    got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
    compared++;
    if (got !== {7'd0, 7'd1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset: got pc=%0d inc=%0d w/e/f/err=%b%b%b%b, want 0 1 0100",
               got.pc, got.inc, got.wrap, got.empty, got.full, got.err);
    end
    model_reset();
    @(negedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ret = 1;
      advance();
      got = {pc, pc_inc, wrap, ras_empty, ras_full, ras_err};
      e = sb.pop_front();
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL post_reset[%0d]: got pc=%0d inc=%0d e/f/err=%b%b%b, want pc=%0d inc=%0d e/f/err=%b%b%b",
                 i, got.pc, got.inc, got.empty, got.full, got.err, e.pc, e.inc, e.empty, e.full, e.err);
      end
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_stall();
    test_call_return();
    test_ras_overflow();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
